box_position_ctrl: RTL and testbench

- Producer side of the bitmap-object drawing interface. Owns the on-screen top-left position of the player box object.
- Converts the VGA scan coordinates into `offsetX`/`offsetY`/`insideRectangle` for the bitmap block (8x16 bitmap drawn at 2x scale).
- Moves the object once per frame from left/right commands.
- Runs a collision-recovery sequence: return to home position, then blink for a fixed number of frames.

---
 rtl/game_pkg.sv | 15 +
 rtl/box_position_ctrl_rect_offset_calc.sv | 63 ++++++
 rtl/box_position_ctrl.sv | 143 ++++++++++++++
 tb/tb_box_position_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: screen geometry, coordinate type and the box FSM states.
package game_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 11;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic {
        RUN = 1'b0,
        HIT = 1'b1
    } box_state_t;

endpackage

// File: rtl/box_position_ctrl_rect_offset_calc.sv
// Registered inside-box test and offset generator for any bitmap object.
// A blank request suppresses the inside flag but still produces offsets.
module rect_offset_calc
    import game_pkg::*;
#(
    parameter int OBJECT_WIDTH_X  = 16,
    parameter int OBJECT_HEIGHT_Y = 32
) (
    input  logic   clk,
    input  logic   reset,
    input  coord_t pixelX,
    input  coord_t pixelY,
    input  coord_t topLeftX,
    input  coord_t topLeftY,
    input  logic   blank,
    output coord_t offsetX,
    output coord_t offsetY,
    output logic   insideRectangle
);

    logic [COORD_W:0] px_s, py_s, left_s, top_s, right_s, bottom_s;
    logic             inside_s;
    coord_t           off_x_s, off_y_s;
    coord_t           off_x_r, off_y_r;
    logic             inside_r;

    // Widened compare so topLeft + size never wraps.
    always_comb begin
        px_s     = {1'b0, pixelX};
        py_s     = {1'b0, pixelY};
        left_s   = {1'b0, topLeftX};
        top_s    = {1'b0, topLeftY};
        right_s  = left_s + (COORD_W+1)'(OBJECT_WIDTH_X);
        bottom_s = top_s + (COORD_W+1)'(OBJECT_HEIGHT_Y);
        inside_s = (px_s >= left_s) && (px_s < right_s) &&
                   (py_s >= top_s)  && (py_s < bottom_s);
        if (inside_s) begin
            off_x_s = pixelX - topLeftX;
            off_y_s = pixelY - topLeftY;
        end else begin
            off_x_s = {COORD_W{1'b0}};
            off_y_s = {COORD_W{1'b0}};
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            off_x_r  <= {COORD_W{1'b0}};
            off_y_r  <= {COORD_W{1'b0}};
            inside_r <= 1'b0;
        end else begin
            off_x_r  <= off_x_s;
            off_y_r  <= off_y_s;
            inside_r <= inside_s && !blank;
        end
    end

    assign offsetX         = off_x_r;
    assign offsetY         = off_y_r;
    assign insideRectangle = inside_r;

endmodule

// File: rtl/box_position_ctrl.sv
// Player box position owner: per-frame left/right movement with clamping,
// plus collision recovery (return home, then blink for HIT_FRAMES frames).
module box_position_ctrl
    import game_pkg::*;
#(
    parameter int OBJECT_WIDTH_X  = 16,
    parameter int OBJECT_HEIGHT_Y = 32,
    parameter int INIT_X          = 312,
    parameter int INIT_Y          = 440,
    parameter int SPEED           = 4,
    parameter int HIT_FRAMES      = 30
) (
    input  logic   clk,
    input  logic   reset,
    input  coord_t pixelX,
    input  coord_t pixelY,
    input  logic   startOfFrame,
    input  logic   moveLeft,
    input  logic   moveRight,
    input  logic   collision,
    output coord_t offsetX,
    output coord_t offsetY,
    output logic   insideRectangle,
    output coord_t topLeftX,
    output coord_t topLeftY,
    output logic   inRecovery
);

    localparam int     CNT_W   = $clog2(HIT_FRAMES);
    localparam coord_t MAX_X   = coord_t'(SCREEN_W - OBJECT_WIDTH_X);
    localparam coord_t HOME_X  = coord_t'(INIT_X);
    localparam coord_t HOME_Y  = coord_t'(INIT_Y);
    localparam coord_t STEP    = coord_t'(SPEED);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HIT_FRAMES - 1);

    box_state_t       state_r;
    logic             hit_latch_r;
    logic [CNT_W-1:0] frame_cnt_r;
    coord_t           top_left_x_r;
    logic             in_recovery_r;
    coord_t           move_x_s;
    logic             hit_pending_s;
    logic             blank_s;

    assign hit_pending_s = hit_latch_r || collision;
    assign blank_s       = (state_r == HIT) && frame_cnt_r[2];

    // Saturating candidate position for this frame's move request.
    always_comb begin
        if (moveLeft && !moveRight) begin
            if (top_left_x_r < STEP) begin
                move_x_s = {COORD_W{1'b0}};
            end else begin
                move_x_s = top_left_x_r - STEP;
            end
        end else if (moveRight && !moveLeft) begin
            if (top_left_x_r > (MAX_X - STEP)) begin
                move_x_s = MAX_X;
            end else begin
                move_x_s = top_left_x_r + STEP;
            end
        end else begin
            move_x_s = top_left_x_r;
        end
    end

    // Hit latch remembers a RUN-state collision until the next frame boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_latch_r <= 1'b0;
        end else if (startOfFrame) begin
            hit_latch_r <= 1'b0;
        end else if (collision && (state_r == RUN)) begin
            hit_latch_r <= 1'b1;
        end else begin
            hit_latch_r <= hit_latch_r;
        end
    end

    // Frame-rate FSM: position, recovery counter and recovery flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= RUN;
            frame_cnt_r   <= {CNT_W{1'b0}};
            top_left_x_r  <= HOME_X;
            in_recovery_r <= 1'b0;
        end else if (startOfFrame) begin
            case (state_r)
                RUN: begin
                    if (hit_pending_s) begin
                        state_r       <= HIT;
                        frame_cnt_r   <= {CNT_W{1'b0}};
                        top_left_x_r  <= HOME_X;
                        in_recovery_r <= 1'b1;
                    end else begin
                        top_left_x_r  <= move_x_s;
                    end
                end
                HIT: begin
                    if (frame_cnt_r == LAST_CNT) begin
                        state_r       <= RUN;
                        frame_cnt_r   <= {CNT_W{1'b0}};
                        in_recovery_r <= 1'b0;
                    end else begin
                        frame_cnt_r   <= frame_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r       <= RUN;
                    frame_cnt_r   <= {CNT_W{1'b0}};
                    top_left_x_r  <= HOME_X;
                    in_recovery_r <= 1'b0;
                end
            endcase
        end else begin
            state_r       <= state_r;
            frame_cnt_r   <= frame_cnt_r;
            top_left_x_r  <= top_left_x_r;
            in_recovery_r <= in_recovery_r;
        end
    end

    rect_offset_calc #(
        .OBJECT_WIDTH_X  (OBJECT_WIDTH_X),
        .OBJECT_HEIGHT_Y (OBJECT_HEIGHT_Y)
    ) u_rect (
        .clk             (clk),
        .reset           (reset),
        .pixelX          (pixelX),
        .pixelY          (pixelY),
        .topLeftX        (top_left_x_r),
        .topLeftY        (HOME_Y),
        .blank           (blank_s),
        .offsetX         (offsetX),
        .offsetY         (offsetY),
        .insideRectangle (insideRectangle)
    );

    assign topLeftX   = top_left_x_r;
    assign topLeftY   = HOME_Y;
    assign inRecovery = in_recovery_r;

endmodule

// File: tb/tb_box_position_ctrl.sv
// Directed bench for box_position_ctrl: rectangle path, movement/clamping,
// collision recovery with blink, coincident and repeated collisions, reset.
module tb_box_position_ctrl;

    logic        clk;
    logic        reset;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    logic        moveLeft;
    logic        moveRight;
    logic        collision;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        insideRectangle;
    logic [10:0] topLeftX;
    logic [10:0] topLeftY;
    logic        inRecovery;

    int pass_cnt = 0;
    int total_cnt = 0;

    box_position_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .pixelX          (pixelX),
        .pixelY          (pixelY),
        .startOfFrame    (startOfFrame),
        .moveLeft        (moveLeft),
        .moveRight       (moveRight),
        .collision       (collision),
        .offsetX         (offsetX),
        .offsetY         (offsetY),
        .insideRectangle (insideRectangle),
        .topLeftX        (topLeftX),
        .topLeftY        (topLeftY),
        .inRecovery      (inRecovery)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sof();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    initial begin
        reset = 1'b1; pixelX = 11'd0; pixelY = 11'd0; startOfFrame = 1'b0;
        moveLeft = 1'b0; moveRight = 1'b0; collision = 1'b0;
        tick(); tick();
        check("rst_x", 32'(topLeftX), 32'd312);
        check("rst_y", 32'(topLeftY), 32'd440);
        check("rst_inside", 32'(insideRectangle), 32'd0);
        check("rst_offx", 32'(offsetX), 32'd0);
        check("rst_rec", 32'(inRecovery), 32'd0);
        reset = 1'b0;

        // Rectangle path
        pixelX = 11'd315; pixelY = 11'd450; tick();
        check("in_inside", 32'(insideRectangle), 32'd1);
        check("in_offx", 32'(offsetX), 32'd3);
        check("in_offy", 32'(offsetY), 32'd10);
        pixelX = 11'd328; tick();
        check("right_edge_inside", 32'(insideRectangle), 32'd0);
        check("right_edge_offx", 32'(offsetX), 32'd0);
        check("right_edge_offy", 32'(offsetY), 32'd0);
        pixelX = 11'd327; pixelY = 11'd471; tick();
        check("corner_inside", 32'(insideRectangle), 32'd1);
        check("corner_offx", 32'(offsetX), 32'd15);
        check("corner_offy", 32'(offsetY), 32'd31);
        pixelY = 11'd472; tick();
        check("bottom_edge_inside", 32'(insideRectangle), 32'd0);
        pixelX = 11'd311; pixelY = 11'd440; tick();
        check("left_edge_inside", 32'(insideRectangle), 32'd0);

        // Movement
        moveRight = 1'b1;
        sof(); sof(); sof();
        check("right3", 32'(topLeftX), 32'd324);
        for (int i = 0; i < 75; i++) sof();
        check("right_to_max", 32'(topLeftX), 32'd624);
        sof();
        check("right_clamp", 32'(topLeftX), 32'd624);
        moveRight = 1'b0; moveLeft = 1'b1;
        for (int i = 0; i < 155; i++) sof();
        check("left_to_4", 32'(topLeftX), 32'd4);
        sof();
        check("left_to_0", 32'(topLeftX), 32'd0);
        sof();
        check("left_clamp", 32'(topLeftX), 32'd0);
        moveRight = 1'b1;
        sof();
        check("both_held", 32'(topLeftX), 32'd0);
        moveLeft = 1'b0; moveRight = 1'b0;
        sof();
        check("none_held", 32'(topLeftX), 32'd0);
        moveRight = 1'b1;
        for (int i = 0; i < 100; i++) sof();
        check("right_to_400", 32'(topLeftX), 32'd400);
        moveRight = 1'b0; moveLeft = 1'b1;
        repeat (1000) tick();
        check("no_sof_hold", 32'(topLeftX), 32'd400);
        moveLeft = 1'b0;

        // Collision recovery
        collision = 1'b1; tick(); collision = 1'b0;
        tick(); tick();
        check("latched_no_move", 32'(topLeftX), 32'd400);
        check("latched_rec", 32'(inRecovery), 32'd0);
        moveRight = 1'b1;
        pixelX = 11'd315; pixelY = 11'd450;
        sof();
        check("hit_home", 32'(topLeftX), 32'd312);
        check("hit_rec", 32'(inRecovery), 32'd1);
        tick();
        check("blink_f0", 32'(insideRectangle), 32'd1);
        for (int k = 1; k <= 29; k++) begin
            if (k == 10) begin
                collision = 1'b1; tick(); collision = 1'b0;
            end
            sof();
            tick();
            check($sformatf("hit_rec_f%0d", k), 32'(inRecovery), 32'd1);
            check($sformatf("hit_x_f%0d", k), 32'(topLeftX), 32'd312);
            check($sformatf("blink_f%0d", k), 32'(insideRectangle), ((k / 4) % 2 == 1) ? 32'd0 : 32'd1);
            check($sformatf("blink_offx_f%0d", k), 32'(offsetX), 32'd3);
        end
        sof();
        check("exit_rec", 32'(inRecovery), 32'd0);
        check("exit_x", 32'(topLeftX), 32'd312);
        sof();
        check("after_exit_move", 32'(topLeftX), 32'd316);
        check("after_exit_rec", 32'(inRecovery), 32'd0);

        // Collision coincident with the frame boundary
        collision = 1'b1; startOfFrame = 1'b1; tick();
        collision = 1'b0; startOfFrame = 1'b0;
        check("coinc_rec", 32'(inRecovery), 32'd1);
        check("coinc_x", 32'(topLeftX), 32'd312);
        tick();
        check("pre_reset_inside", 32'(insideRectangle), 32'd1);

        // Reset mid-recovery
        reset = 1'b1; tick(); reset = 1'b0;
        check("midhit_rst_rec", 32'(inRecovery), 32'd0);
        check("midhit_rst_inside", 32'(insideRectangle), 32'd0);
        check("midhit_rst_x", 32'(topLeftX), 32'd312);
        moveRight = 1'b0; moveLeft = 1'b1;
        sof();
        check("post_rst_move", 32'(topLeftX), 32'd308);
        moveLeft = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
